// File: rtl/mips_pkg.sv
// Shared core definitions: divider state encoding and default datapath width.
package mips_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_ITER = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DIV_IDLE,
    ST_ITER = DIV_ITER,
    ST_FIX  = DIV_FIX
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX-stage hazard logic and the divider.
interface div_unit_if import mips_pkg::*; #(parameter int WIDTH = DIV_WIDTH);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {rem, quo} register pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The extra top bit acts as the borrow: set means the subtraction went negative.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division, one bit per clock,
// followed by a single sign fix-up cycle.
module div_unit import mips_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dvnd_raw_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             neg_quo_q, neg_rem_q, dbz_q, div_by_zero_q, done_q;
  logic [WIDTH-1:0] rem_nx, quo_nx, abs_dvnd, abs_dvsr;

  always_comb begin
    abs_dvnd = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    abs_dvsr = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_nx),
    .quo_o  (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start)     state_d = ST_ITER;
      ST_ITER: if (cnt_q == LAST) state_d = ST_FIX;
      ST_FIX:                     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      dvnd_raw_q    <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FIX);
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          quo_q      <= abs_dvnd;
          rem_q      <= '0;
          dvsr_q     <= abs_dvsr;
          dvnd_raw_q <= bus.dividend;
          neg_quo_q  <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_q  <= bus.is_signed & bus.dividend[WIDTH-1];
          dbz_q      <= (bus.divisor == '0);
          cnt_q      <= '0;
        end
        ST_ITER: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + CW'(1);
        end
        ST_FIX: begin
          // A zero divisor reports the untouched dividend, never sign-corrected.
          if (dbz_q) begin
            quotient_q  <= '1;
            remainder_q <= dvnd_raw_q;
          end else begin
            quotient_q  <= neg_quo_q ? -quo_q : quo_q;
            remainder_q <= neg_rem_q ? -rem_q : rem_q;
          end
          div_by_zero_q <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against an arithmetic reference model.
module tb_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) dif ();

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // DIV/DIVU semantics from plain integer arithmetic.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int poke, input string tag);
    logic [31:0] eq, er;
    int lat;
    bit busy_ok;
    model(s, a, b, eq, er);
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = s; dif.dividend = a; dif.divisor = b;
    @(posedge clk); #1;
    dif.start = 1'b0;
    dif.is_signed = 1'($urandom); dif.dividend = $urandom; dif.divisor = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!dif.done && lat < 100) begin
      if (!dif.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      dif.start = (lat == poke);
      if (lat == poke) begin
        dif.dividend = $urandom; dif.divisor = $urandom;
      end
    end
    dif.start = 1'b0;
    check({tag, " latency"}, lat, 33);
    check({tag, " busy_during"}, busy_ok, 1);
    check({tag, " busy_at_done"}, dif.busy, 0);
    check({tag, " quotient"}, dif.quotient, eq);
    check({tag, " remainder"}, dif.remainder, er);
    check({tag, " dbz"}, dif.div_by_zero, (b == 0));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, dif.done, 0);
    check({tag, " q_hold"}, dif.quotient, eq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, eq, er;
    int seen_done, cyc;
    int times[$];

    dif.start = 1'b0; dif.is_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    #12;
    check("rst quotient",  dif.quotient, 0);
    check("rst remainder", dif.remainder, 0);
    check("rst busy",      dif.busy, 0);
    check("rst done",      dif.done, 0);
    check("rst dbz",       dif.div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    do_op(1'b1, -32'sd7, 32'd2, 0, "div_m7_2");
    do_op(1'b1, 32'd7, -32'sd2, 0, "div_7_m2");
    do_op(1'b1, -32'sd7, -32'sd2, 0, "div_m7_m2");
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_ovf");
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
    do_op(1'b0, 32'h1234, 32'd0, 0, "divu_zero");
    do_op(1'b1, 32'h1234, 32'd0, 0, "div_zero");
    do_op(1'b1, 32'hFFFF_FF00, 32'd0, 0, "div_negzero");
    do_op(1'b0, 32'd1000, 32'd9, 5, "restart_ignored");

    // Abort mid-iteration with asynchronous reset.
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'hFFFF; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort quotient",  dif.quotient, 0);
    check("abort remainder", dif.remainder, 0);
    check("abort dbz",       dif.div_by_zero, 0);
    check("abort busy",      dif.busy, 0);
    check("abort done",      dif.done, 0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.done) seen_done++;
    end
    check("abort no_done", seen_done, 0);
    do_op(1'b0, 32'd9, 32'd3, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: begin a = $urandom_range(0, 500); b = $urandom_range(1, 40); end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        default: begin a = $urandom; b = $urandom_range(1, 255); if ($urandom_range(0, 1) != 0) b = -b; end
      endcase
      do_op(1'($urandom), a, b, 0, $sformatf("rand%0d", i));
    end

    // Start held high: back-to-back operations one IDLE cycle apart.
    model(1'b1, -32'sd100, 32'd7, eq, er);
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = 1'b1; dif.dividend = -32'sd100; dif.divisor = 32'd7;
    for (cyc = 1; cyc <= 120; cyc++) begin
      @(posedge clk); #1;
      if (dif.done) begin
        times.push_back(cyc);
        check("held quotient",  dif.quotient, eq);
        check("held remainder", dif.remainder, er);
      end
    end
    dif.start = 1'b0;
    check("held done_count", (times.size() >= 3), 1);
    for (int i = 1; i < times.size(); i++)
      check("held interval", times[i] - times[i-1], 34);
    repeat (40) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the pipelined MIPS core, serving DIV and DIVU and producing the LO (quotient) and HI (remainder) values. It is the subtractive counterpart of the datapath adders. It runs a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the EX stage: the hazard unit stalls the pipeline while `busy` is high and captures results on `done`.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a division. Sampled only in IDLE.
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `dividend`  in  WIDTH  numerator, sampled with `start`.
- `divisor`  in  WIDTH  denominator, sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle pulse: results valid.
- `quotient`  out  WIDTH  LO result.
- `remainder`  out  WIDTH  HI result.
- `div_by_zero`  out  1  last completed operation had divisor == 0.

## Operation
- States: IDLE, ITER, FIX.
- **IDLE.** On `start`=1:
  - capture |dividend| and |divisor| (absolute values only when `is_signed`=1; raw operands otherwise);
  - capture the raw dividend, sign flags and zero-divisor flag;
  - clear the partial remainder, set the iteration count to 0, go to ITER.
- **ITER.** Runs exactly WIDTH cycles. Each cycle:
  - shift {rem, quo} left by 1;
  - trial = rem - divisor, computed at WIDTH+1 bits;
  - if the trial is non-negative, rem = trial and quo[0] = 1; else quo[0] = 0.
  - After the cycle with count == WIDTH-1, go to FIX.
- **FIX.** One cycle. Register the outputs, pulse `done`, return to IDLE.
  - Quotient is negated iff `is_signed` and the operand signs differ.
  - Remainder is negated iff `is_signed` and the dividend is negative. Division truncates toward zero.
  - Divisor == 0: no sign correction; quotient = all ones, remainder = raw captured dividend, `div_by_zero` = 1. The same cycle count applies.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the WIDTH-bit unsigned magnitude path with no special case.
- `start` while busy is ignored. Operand changes after the `start` edge have no effect.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next FIX; they change only there.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE;
  - `busy`, `done`, `div_by_zero` = 0;
  - `quotient`, `remainder` = 0;
  - internal registers cleared.
- Latency: with `start` sampled at edge E0, `done`=1 and the results are valid after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
- `busy` is 1 from after E0 through the FIX cycle. It falls in the same cycle `done` rises.
- `done` is high for exactly one cycle.
- `start` held high across the `done` cycle is re-sampled in IDLE the next cycle. Back-to-back operations are therefore separated by one IDLE cycle.
- Reset asserted mid-ITER aborts the operation: no `done`, and outputs return to reset values.
- The iteration counter is log2(WIDTH)+1 bits and does not wrap during an operation.

## Structure
- Shared package `mips_pkg`:
  - state encoding localparams DIV_IDLE=2'd0, DIV_ITER=2'd1, DIV_FIX=2'd2;
  - the default `WIDTH`.
- One sub-module, `div_step`: combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in the ITER datapath.
- Sign fix-up and absolute-value logic stay inline in `div_unit`.

## Test plan
- DIVU 100 / 7 → quotient 14, remainder 2, `div_by_zero`=0; `done` exactly 33 cycles after `start`; `busy` high for those cycles.
- DIV −7 / 2 → 0xFFFFFFFD / 0xFFFFFFFF.
- DIV 7 / −2 → 0xFFFFFFFD / 0x00000001.
- DIV −7 / −2 → 0x00000003 / 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 / 0.
- DIVU of the same operands → 0 / 0x80000000.
- DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF / 0.
- DIVU and DIV 0x1234 / 0 → quotient 0xFFFFFFFF, remainder 0x1234, `div_by_zero`=1, 33-cycle latency.
- Second `start` with new operands at cycle 5 of an operation → ignored; the first result is correct.
- Reset asserted at cycle 10 of an operation → all outputs 0 immediately, no `done`. A following DIVU 9 / 3 → 3 / 0.
- `start` held high continuously with constant operands → `done` pulses every 34 cycles with identical results.
